mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and performs load/store through a req/ack data-memory handshake.
- Stalls the upstream pipeline while an access is outstanding, then registers the result into the MEM/WB register.
- MEMWB outputs feed writeback and the forwarding unit.

Parameters:
TIMEOUT, 16, max cycles waiting for DMEM_ACK before the access is abandoned (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
EXMEM_OPCODE  in  5  opcode from EX/MEM (5'h1f = NOP)
EXMEM_RD_ADDR  in  3  destination register
EXMEM_RD_DATA  in  8  store data
EXMEM_ALU_OUT  in  8  ALU result / memory address
DMEM_REQ  out  1  access request, registered
DMEM_WE  out  1  1 = store, 0 = load, registered
DMEM_ADDR  out  8  registered address
DMEM_WDATA  out  8  registered store data
DMEM_RDATA  in  8  load data, valid with DMEM_ACK
DMEM_ACK  in  1  access complete
MEM_STALL  out  1  combinational; holds PC/IFID/IDEX/EXMEM
MEM_ERR  out  1  sticky timeout flag
MEMWB_OPCODE  out  5  registered opcode
MEMWB_RD_ADDR  out  3  registered destination
MEMWB_WB_DATA  out  8  registered writeback data
MEMWB_WB_EN  out  1  registered register-write enable

Behaviour:
- Reset (rst low, async): state IDLE; DMEM_REQ/WE = 0; DMEM_ADDR/WDATA = 0; MEMWB_OPCODE = 5'h1f; MEMWB_RD_ADDR/WB_DATA = 0; WB_EN = 0; MEM_ERR = 0; timeout counter = 0.
- MEM_STALL is forced to 0 while rst is low. Reset mid-access drops DMEM_REQ immediately and discards the access.
- Opcode classes:
  - is_mem = opcode in {OP_LD, OP_ST}.
  - wb_class = opcode < OP_BR_BASE and opcode != OP_ST. Covers OP_LD and ALU ops.
  - Opcodes 5'h18..5'h1f do not write back.
- FSM: IDLE, ACCESS.
- IDLE, non-mem opcode:
  - 1-cycle pass-through. Next edge: MEMWB_OPCODE <= opcode; RD_ADDR <= EXMEM_RD_ADDR; WB_DATA <= ALU_OUT; WB_EN <= wb_class.
  - MEM_STALL = 0.
- IDLE, is_mem:
  - MEM_STALL = 1 in this cycle.
  - Next edge: DMEM_REQ <= 1; WE <= (opcode == OP_ST); ADDR <= ALU_OUT; WDATA <= RD_DATA. Latch opcode and rd_addr internally; counter <= 0; state -> ACCESS.
  - MEMWB loads a bubble (5'h1f, WB_EN = 0).
- ACCESS:
  - EXMEM inputs are ignored; upstream is held by the stall.
  - DMEM_REQ/WE/ADDR/WDATA stay stable until the access ends.
  - DMEM_ACK = 1:
    - MEM_STALL = 0 in that cycle.
    - Next edge: REQ <= 0; state -> IDLE.
    - MEMWB gets the latched opcode and rd_addr. WB_DATA <= DMEM_RDATA for a load; WB_DATA <= 0 with WB_EN = 0 for a store. WB_EN = 1 for a load.
  - DMEM_ACK = 0 and counter == TIMEOUT-1:
    - MEM_STALL = 0.
    - Next edge: REQ <= 0; MEM_ERR <= 1 (sticky until reset); MEMWB bubble; state -> IDLE. The instruction is dropped.
  - Otherwise: MEM_STALL = 1; counter increments; MEMWB bubble.
- Timing and stall rules:
  - Minimum load/store latency is 2 cycles (stall one cycle) with a zero-wait memory. ACK is sampled only in ACCESS; ACK in IDLE is ignored.
  - Because the stall drops in the ack/timeout cycle, EXMEM advances on that same edge. IDLE then sees the next instruction, never the completed one a second time.
  - Back-to-back memory ops: the second enters ACCESS one cycle after the first completes.
- Counter width is $clog2(TIMEOUT+1). TIMEOUT == 1 means a single ACK sample cycle.

Decomposition:
- Package mips_pkg holds:
  - OP_NOP = 5'h1f, OP_LD = 5'h10, OP_ST = 5'h11, OP_BR_BASE = 5'h18.
  - Data width 8, register address width 3.
  - The mem_state_t enum {IDLE, ACCESS}.
  - Functions is_mem(op) and wb_class(op).
- One sub-module: memwb_reg. It holds the registered MEMWB outputs, with load/bubble select and async active-low reset.
- The FSM and handshake stay in mem_stage.

Test Plan:
- Reset: hold rst low 3 cycles with EXMEM_OPCODE = OP_LD -> MEM_STALL = 0, DMEM_REQ = 0, MEMWB_OPCODE = 5'h1f, MEM_ERR = 0.
- ALU pass-through: opcode 5'h02, RD 3'd5, ALU_OUT 8'hA5 -> next edge MEMWB = {5'h02, 5, 8'hA5, WB_EN = 1}, no stall.
- Load with 3-cycle ack delay: OP_LD, ALU_OUT 8'h40, RD 3'd2, RDATA 8'h3C with ACK 3 cycles after REQ -> DMEM_ADDR = 8'h40, WE = 0, MEM_STALL high 4 cycles, then MEMWB = {OP_LD, 2, 8'h3C, 1}, REQ low.
- Zero-wait store then ALU op: OP_ST, addr 8'h10, data 8'h77, ACK in first ACCESS cycle -> WE = 1, WDATA = 8'h77, one stall cycle, MEMWB_WB_EN = 0. The following opcode 5'h03 reaches MEMWB next cycle.
- Timeout with TIMEOUT = 4 and ACK never asserted -> REQ high exactly 4 cycles, then MEM_ERR = 1 (sticky), MEMWB bubble, state IDLE. The next instruction is processed normally.
- Reset mid-ACCESS: assert rst low 2 cycles into a load -> REQ drops asynchronously. After release: IDLE, no stale MEMWB write, MEM_ERR = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcodes, widths and opcode-class helpers for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_NOP     = 5'h1f;
  localparam logic [OP_W-1:0] OP_LD      = 5'h10;
  localparam logic [OP_W-1:0] OP_ST      = 5'h11;
  localparam logic [OP_W-1:0] OP_BR_BASE = 5'h18;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // Loads and ALU ops write back; stores and the branch/NOP block do not.
  function automatic logic wb_class(input logic [OP_W-1:0] op);
    return (op < OP_BR_BASE) && (op != OP_ST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/memwb_reg.sv
// ============================================================================
// Module      : memwb_reg
// Description : MEM/WB pipeline register; loads a result or inserts a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memwb_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [OP_W-1:0]   op_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en_in,
  output logic [OP_W-1:0]   opcode,
  output logic [REG_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode  <= OP_NOP;
      rd_addr <= '0;
      wb_data <= '0;
      wb_en   <= 1'b0;
    end else if (load) begin
      opcode  <= op_in;
      rd_addr <= rd_in;
      wb_data <= data_in;
      wb_en   <= en_in;
    end else begin
      opcode  <= OP_NOP;
      rd_addr <= '0;
      wb_data <= '0;
      wb_en   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage: req/ack data-memory handshake, upstream
//               stall, access timeout and MEM/WB register update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   EXMEM_OPCODE,
  input  logic [REG_W-1:0]  EXMEM_RD_ADDR,
  input  logic [DATA_W-1:0] EXMEM_RD_DATA,
  input  logic [DATA_W-1:0] EXMEM_ALU_OUT,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              MEM_STALL,
  output logic              MEM_ERR,
  output logic [OP_W-1:0]   MEMWB_OPCODE,
  output logic [REG_W-1:0]  MEMWB_RD_ADDR,
  output logic [DATA_W-1:0] MEMWB_WB_DATA,
  output logic              MEMWB_WB_EN
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   lat_op;
  logic [REG_W-1:0]  lat_rd;

  logic              stall;
  logic              start;
  logic              finish;
  logic              timeout_hit;
  logic              wb_load;
  logic [OP_W-1:0]   wb_op;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    start       = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    wb_load     = 1'b0;
    wb_op       = OP_NOP;
    wb_rd       = '0;
    wb_data     = '0;
    wb_en       = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem(EXMEM_OPCODE)) begin
          stall     = 1'b1;
          start     = 1'b1;
          state_nxt = ACCESS;
        end else begin
          wb_load = 1'b1;
          wb_op   = EXMEM_OPCODE;
          wb_rd   = EXMEM_RD_ADDR;
          wb_data = EXMEM_ALU_OUT;
          wb_en   = wb_class(EXMEM_OPCODE);
        end
      end
      ACCESS: begin
        // ACK wins over timeout when both land on the last sample cycle.
        if (DMEM_ACK) begin
          finish    = 1'b1;
          state_nxt = IDLE;
          wb_load   = 1'b1;
          wb_op     = lat_op;
          wb_rd     = lat_rd;
          wb_data   = DMEM_WE ? '0 : DMEM_RDATA;
          wb_en     = ~DMEM_WE;
        end else if (cnt == CNT_LAST) begin
          finish      = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign MEM_STALL = rst & stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DMEM_REQ   <= 1'b0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
      MEM_ERR    <= 1'b0;
      cnt        <= '0;
      lat_op     <= OP_NOP;
      lat_rd     <= '0;
    end else begin
      if (start) begin
        DMEM_REQ   <= 1'b1;
        DMEM_WE    <= (EXMEM_OPCODE == OP_ST);
        DMEM_ADDR  <= EXMEM_ALU_OUT;
        DMEM_WDATA <= EXMEM_RD_DATA;
        lat_op     <= EXMEM_OPCODE;
        lat_rd     <= EXMEM_RD_ADDR;
        cnt        <= '0;
      end else if (finish) begin
        DMEM_REQ <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) MEM_ERR <= 1'b1;
    end
  end

  memwb_reg u_memwb_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (wb_load),
    .op_in   (wb_op),
    .rd_in   (wb_rd),
    .data_in (wb_data),
    .en_in   (wb_en),
    .opcode  (MEMWB_OPCODE),
    .rd_addr (MEMWB_RD_ADDR),
    .wb_data (MEMWB_WB_DATA),
    .wb_en   (MEMWB_WB_EN)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import mips_pkg::*;

  localparam int TO = 4;
  localparam int NEVER = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] EXMEM_OPCODE = OP_LD;
  logic [2:0] EXMEM_RD_ADDR = '0;
  logic [7:0] EXMEM_RD_DATA = '0;
  logic [7:0] EXMEM_ALU_OUT = '0;
  logic       DMEM_REQ, DMEM_WE;
  logic [7:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0] DMEM_RDATA = '0;
  logic       DMEM_ACK = 1'b0;
  logic       MEM_STALL, MEM_ERR;
  logic [4:0] MEMWB_OPCODE;
  logic [2:0] MEMWB_RD_ADDR;
  logic [7:0] MEMWB_WB_DATA;
  logic       MEMWB_WB_EN;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .EXMEM_OPCODE(EXMEM_OPCODE), .EXMEM_RD_ADDR(EXMEM_RD_ADDR),
    .EXMEM_RD_DATA(EXMEM_RD_DATA), .EXMEM_ALU_OUT(EXMEM_ALU_OUT),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .MEM_STALL(MEM_STALL), .MEM_ERR(MEM_ERR),
    .MEMWB_OPCODE(MEMWB_OPCODE), .MEMWB_RD_ADDR(MEMWB_RD_ADDR),
    .MEMWB_WB_DATA(MEMWB_WB_DATA), .MEMWB_WB_EN(MEMWB_WB_EN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [2:0] rd;
    logic [7:0] data;
    logic       en;
  } wb_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;
  } req_t;

  wb_t        sb_q[$];
  req_t       req_q[$];
  logic [7:0] ref_mem[256];
  logic [7:0] dmem[256];
  logic       err_exp = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every non-NOP MEMWB word must be the next scoreboard entry.
  always @(negedge clk) begin
    wb_t e;
    if (MEMWB_OPCODE !== OP_NOP) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got op %0h with nothing expected", MEMWB_OPCODE);
      end else begin
        e = sb_q.pop_front();
        check("wb_op",   32'(MEMWB_OPCODE),  32'(e.op));
        check("wb_rd",   32'(MEMWB_RD_ADDR), 32'(e.rd));
        check("wb_data", 32'(MEMWB_WB_DATA), 32'(e.data));
        check("wb_en",   32'(MEMWB_WB_EN),   32'(e.en));
      end
    end else begin
      check("bubble_en", 32'(MEMWB_WB_EN), 32'd0);
    end
  end

  // Memory responder: acks after the scripted number of wait cycles and
  // throws random ACK/RDATA noise while no request is outstanding.
  bit   busy = 1'b0;
  bit   rogue = 1'b0;
  int   rcnt = 0;
  req_t cur;
  always @(negedge clk) begin
    if (DMEM_REQ === 1'b1) begin
      if (!busy) begin
        busy  = 1'b1;
        rcnt  = 0;
        rogue = (req_q.size() == 0);
        if (rogue) begin
          total++;
          bad++;
          $display("FAIL dmem_unexpected: got request at addr %0h with none expected", DMEM_ADDR);
          cur.delay = NEVER;
        end else begin
          cur = req_q.pop_front();
        end
      end
      if (!rogue) begin
        check("dmem_we",   32'(DMEM_WE),   32'(cur.we));
        check("dmem_addr", 32'(DMEM_ADDR), 32'(cur.addr));
        if (cur.we) check("dmem_wdata", 32'(DMEM_WDATA), 32'(cur.wdata));
      end
      if (rcnt == cur.delay) begin
        DMEM_ACK   = 1'b1;
        DMEM_RDATA = dmem[DMEM_ADDR];
        if (DMEM_WE) dmem[DMEM_ADDR] = DMEM_WDATA;
      end else begin
        DMEM_ACK   = 1'b0;
        DMEM_RDATA = 8'($urandom);
      end
      rcnt++;
    end else begin
      busy       = 1'b0;
      DMEM_ACK   = 1'($urandom_range(0, 1));
      DMEM_RDATA = 8'($urandom);
    end
  end

  // Issues one instruction at a negedge, holds it while stalled and returns
  // at the negedge following the edge that accepted it.
  task automatic issue(input logic [4:0] op, input logic [2:0] rd,
                       input logic [7:0] rdd, input logic [7:0] alu, input int delay);
    bit mem_op;
    bit timed;
    int stalls;
    int exp_stalls;
    mem_op = (op == OP_LD) || (op == OP_ST);
    timed  = mem_op && (delay >= TO);
    if (mem_op) req_q.push_back('{op == OP_ST, alu, rdd, delay});
    if (op == OP_LD) begin
      if (!timed) sb_q.push_back('{op, rd, ref_mem[alu], 1'b1});
    end else if (op == OP_ST) begin
      if (!timed) begin
        sb_q.push_back('{op, rd, 8'h00, 1'b0});
        ref_mem[alu] = rdd;
      end
    end else begin
      sb_q.push_back('{op, rd, alu, op <= 5'h17});
    end
    exp_stalls = !mem_op ? 0 : (timed ? TO : 1 + delay);
    EXMEM_OPCODE  = op;
    EXMEM_RD_ADDR = rd;
    EXMEM_RD_DATA = rdd;
    EXMEM_ALU_OUT = alu;
    stalls = 0;
    #1;
    while (MEM_STALL !== 1'b0 && stalls < 64) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
    if (timed) err_exp = 1'b1;
    check("mem_err", 32'(MEM_ERR), 32'(err_exp));
    check("req_done", 32'(DMEM_REQ), 32'd0);
  endtask

  initial begin
    logic [4:0] op;
    int         dly;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      dmem[i]    = ref_mem[i];
    end
    ref_mem[8'h40] = 8'h3C;
    dmem[8'h40]    = 8'h3C;

    // Reset held with a load presented
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall",  32'(MEM_STALL),    32'd0);
    check("rst_req",    32'(DMEM_REQ),     32'd0);
    check("rst_wb_op",  32'(MEMWB_OPCODE), 32'h1f);
    check("rst_err",    32'(MEM_ERR),      32'd0);
    EXMEM_OPCODE = OP_NOP;
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    issue(5'h02, 3'd5, 8'h00, 8'hA5, 0);
    issue(OP_LD, 3'd2, 8'h00, 8'h40, 3);
    issue(OP_ST, 3'd1, 8'h77, 8'h10, 0);
    issue(5'h03, 3'd4, 8'h00, 8'h5A, 0);
    issue(OP_LD, 3'd6, 8'h00, 8'h10, TO - 1);
    issue(5'h1a, 3'd3, 8'h00, 8'h11, 0);
    issue(OP_LD, 3'd7, 8'h00, 8'h22, NEVER);
    issue(5'h05, 3'd1, 8'h00, 8'hC3, 0);

    // Randomized mix of ALU, branch-class, load and store traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_LD;
        3, 4:    op = OP_ST;
        default: op = 5'($urandom_range(0, 30));
      endcase
      dly = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, TO);
      issue(op, 3'($urandom), 8'($urandom), 8'($urandom_range(0, 15)), dly);
    end

    // Reset two cycles into an outstanding load
    EXMEM_OPCODE  = OP_LD;
    EXMEM_ALU_OUT = 8'h55;
    req_q.push_back('{1'b0, 8'h55, 8'h00, NEVER});
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_req", 32'(DMEM_REQ), 32'd1);
    rst = 1'b0;
    #1;
    check("async_req_drop", 32'(DMEM_REQ),  32'd0);
    check("rst_stall_mid",  32'(MEM_STALL), 32'd0);
    EXMEM_OPCODE = OP_NOP;
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_err",  32'(MEM_ERR),  32'd0);
    check("post_rst_req",  32'(DMEM_REQ), 32'd0);
    check("post_rst_sb",   32'(sb_q.size()), 32'd0);
    issue(5'h04, 3'd2, 8'h00, 8'h99, 0);
    issue(OP_ST, 3'd3, 8'hE1, 8'h07, 1);
    issue(OP_LD, 3'd5, 8'h00, 8'h07, 2);

    EXMEM_OPCODE = OP_NOP;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_sb",  32'(sb_q.size()),  32'd0);
    check("drain_req", 32'(req_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
